// File: rtl/vote_entry_controller.sv
// Voter session sequencer: collects a two-digit BCD choice, commits or cancels it,
// keeps candidate/null/blank tallies and locks the booth for a fixed time after each vote.
module vote_entry_controller #(
    parameter int          CNT_W       = 8,
    parameter logic [7:0]  CAND0       = 8'h13,
    parameter logic [7:0]  CAND1       = 8'h45,
    parameter logic [7:0]  CAND2       = 8'h22,
    parameter logic [7:0]  CAND3       = 8'h77,
    parameter int          LOCK_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             digit_vld,
    input  logic [3:0]       digit,
    input  logic             confirm,
    input  logic             cancel,
    output logic [3:0]       bcd1,
    output logic [3:0]       bcd2,
    output logic             busy,
    output logic             vote_done,
    input  logic [2:0]       rd_sel,
    output logic [CNT_W-1:0] rd_cnt
);

    localparam int LCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [2:0] IDX_NULL  = 3'd4;
    localparam logic [2:0] IDX_BLANK = 3'd5;

    typedef enum logic [1:0] {IDLE, TENS, REVIEW, LOCK} state_t;

    state_t           state, state_nxt;
    logic [LCK_W-1:0] lock_cnt;
    logic [CNT_W-1:0] tally [0:5];

    logic       digit_ok;
    logic       lock_done;
    logic       ld_tens, ld_units, clr_digits;
    logic       tally_inc;
    logic [2:0] tally_idx;
    logic [2:0] match_idx;

    assign digit_ok  = digit_vld && (digit <= 4'd9);
    assign lock_done = (lock_cnt == LCK_W'(LOCK_CYCLES - 1));
    assign busy      = (state == LOCK);

    // Lowest candidate index wins if codes are duplicated; no match counts as null.
    always_comb begin
        match_idx = IDX_NULL;
        if ({bcd1, bcd2} == CAND0)      match_idx = 3'd0;
        else if ({bcd1, bcd2} == CAND1) match_idx = 3'd1;
        else if ({bcd1, bcd2} == CAND2) match_idx = 3'd2;
        else if ({bcd1, bcd2} == CAND3) match_idx = 3'd3;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Key priority is cancel over confirm over digit in every state.
    always_comb begin
        state_nxt  = state;
        ld_tens    = 1'b0;
        ld_units   = 1'b0;
        clr_digits = 1'b0;
        tally_inc  = 1'b0;
        tally_idx  = IDX_BLANK;
        case (state)
            IDLE: begin
                if (!cancel && confirm) begin
                    tally_inc = 1'b1;
                    tally_idx = IDX_BLANK;
                    state_nxt = LOCK;
                end else if (!cancel && digit_ok) begin
                    ld_tens   = 1'b1;
                    state_nxt = TENS;
                end
            end
            TENS: begin
                if (cancel) begin
                    clr_digits = 1'b1;
                    state_nxt  = IDLE;
                end else if (!confirm && digit_ok) begin
                    ld_units  = 1'b1;
                    state_nxt = REVIEW;
                end
            end
            REVIEW: begin
                if (cancel) begin
                    clr_digits = 1'b1;
                    state_nxt  = IDLE;
                end else if (confirm) begin
                    tally_inc = 1'b1;
                    tally_idx = match_idx;
                    state_nxt = LOCK;
                end
            end
            LOCK: begin
                if (lock_done) begin
                    clr_digits = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd1      <= 4'hF;
            bcd2      <= 4'hF;
            lock_cnt  <= '0;
            vote_done <= 1'b0;
        end else begin
            vote_done <= tally_inc;
            if (clr_digits) begin
                bcd1 <= 4'hF;
                bcd2 <= 4'hF;
            end else if (ld_tens) begin
                bcd1 <= digit;
            end else if (ld_units) begin
                bcd2 <= digit;
            end
            if (state == LOCK && !lock_done) lock_cnt <= lock_cnt + LCK_W'(1);
            else                             lock_cnt <= '0;
        end
    end

    // Tallies stick at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 6; i++) tally[i] <= '0;
        end else if (tally_inc && (tally[tally_idx] != {CNT_W{1'b1}})) begin
            tally[tally_idx] <= tally[tally_idx] + CNT_W'(1);
        end
    end

    always_comb begin
        rd_cnt = '0;
        if (rd_sel <= 3'd5) rd_cnt = tally[rd_sel];
    end

endmodule
